// File: rtl/peripheral_mpram_wb_pkg.sv
// Shared types and constants for the multi-port RAM Wishbone initiator.
// Cycle-type, burst-type codes and the initiator FSM state encoding.
package peripheral_mpram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    RESP
  } state_e;

endpackage

// File: rtl/peripheral_mpram_wb_watchdog.sv
// Counts consecutive strobe cycles without a slave response.
// Expires on the TIMEOUT-th such cycle; TIMEOUT of 0 never expires.
module peripheral_mpram_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/peripheral_mpram_wb_initiator.sv
// Wishbone B4 initiator: turns a command/data stream into single or
// incrementing-burst cycles on one port of the multi-port RAM.
module peripheral_mpram_wb_initiator
  import peripheral_mpram_wb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic          wdat_valid,
  output logic          wdat_ready,
  input  logic [DW-1:0] wdat,
  output logic          rdat_valid,
  input  logic          rdat_ready,
  output logic [DW-1:0] rdat,
  output logic          done,
  output logic          done_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  state_e state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [LW-1:0] beats_q, beats_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [2:0] cti_q, cti_d;
  logic we_q, we_d;
  logic burst_q, burst_d;
  logic cyc_q, cyc_d;
  logic stb_q, stb_d;
  logic err_q, err_d;
  logic rvld_q, rvld_d;
  logic rdy_q, rdy_d;
  logic done_q, done_d;
  logic derr_q, derr_d;
  logic [LW-1:0] len_eff;
  logic ack, fail, wd_exp, last;

  peripheral_mpram_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (!stb_q || wb_ack_i || wb_err_i),
    .en    (stb_q),
    .expire(wd_exp)
  );

  // err takes priority over a coincident ack
  assign fail    = stb_q && (wb_err_i || wd_exp);
  assign ack     = stb_q && wb_ack_i && !wb_err_i;
  assign last    = (beats_q == LW'(1));
  assign len_eff = (cmd_len == '0) ? LW'(1) : cmd_len;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    beats_d    = beats_q;
    rdat_d     = rdat_q;
    cti_d      = cti_q;
    we_d       = we_q;
    burst_d    = burst_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    err_d      = err_q;
    rvld_d     = rvld_q && !rdat_ready;
    wdat_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          beats_d = len_eff;
          burst_d = (len_eff != LW'(1));
          cyc_d   = 1'b1;
          err_d   = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (fail) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          beats_d = beats_q - 1'b1;
          state_d = (we_q && !last) ? DRAIN : RESP;
        end else if (ack) begin
          stb_d   = 1'b0;
          adr_d   = adr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (!we_q) begin
            rdat_d = wb_dat_i;
            rvld_d = 1'b1;
          end
          if (last) begin
            cyc_d   = 1'b0;
            state_d = RESP;
          end
        end else if (!stb_q) begin
          if (we_q && wdat_valid) begin
            wdat_ready = 1'b1;
            dat_d      = wdat;
            stb_d      = 1'b1;
          end else if (!we_q && (!rvld_q || rdat_ready)) begin
            stb_d = 1'b1;
          end
          if (!burst_q)  cti_d = CTI_CLASSIC;
          else if (last) cti_d = CTI_EOB;
          else           cti_d = CTI_INCR;
        end
      end
      DRAIN: begin
        wdat_ready = 1'b1;
        if (wdat_valid) begin
          beats_d = beats_q - 1'b1;
          if (last) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    done_d = (state_d == RESP);
    derr_d = (state_d == RESP) && err_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      beats_q <= '0;
      rdat_q  <= '0;
      cti_q   <= CTI_CLASSIC;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      beats_q <= beats_d;
      rdat_q  <= rdat_d;
      cti_q   <= cti_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      derr_q  <= derr_d;
    end
  end

  assign cmd_ready  = rdy_q;
  assign rdat_valid = rvld_q;
  assign rdat       = rdat_q;
  assign done       = done_q;
  assign done_err   = derr_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_bte_o   = BTE_LINEAR;
  assign wb_cti_o   = cti_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;

endmodule
